// File: rtl/sys_irq_ctrl.sv
// sys_irq_ctrl: Avalon-MM interrupt controller with up to 16 sources.
// Every source can be edge-capturing (sticky until W1C) or level-following.
// The block also keeps per-source overrun flags, a priority-encoded ACTIVE
// view and a 16-bit tick counter fed by the rising edges of TICK_SRC.
module sys_irq_ctrl #(
  parameter int NUM_IRQ  = 8,
  parameter int TICK_SRC = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic [15:0]        readdata,
  output logic               irq
);

  localparam logic [2:0] A_PEND = 3'd0;
  localparam logic [2:0] A_MASK = 3'd1;
  localparam logic [2:0] A_EDGE = 3'd2;
  localparam logic [2:0] A_ACTV = 3'd3;
  localparam logic [2:0] A_OVRN = 3'd4;
  localparam logic [2:0] A_TICK = 3'd5;

  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] edge_sel_q, edge_sel_d;
  logic [NUM_IRQ-1:0] overrun_q, overrun_d;
  logic [NUM_IRQ-1:0] irq_prev_q;
  logic [15:0]        tick_q, tick_d;
  logic [15:0]        readdata_q, readdata_d;
  logic               irq_q, irq_d;

  logic               wr_en;
  logic [NUM_IRQ-1:0] wdata_src;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] masked;
  logic [NUM_IRQ-1:0] w1c_pend;
  logic [NUM_IRQ-1:0] w1c_ovr;
  logic [NUM_IRQ-1:0] sel_chg;
  logic [3:0]         active_idx;
  logic               tick_inc;
  logic               unused_wdata;

  assign wr_en     = chipselect & ~write_n;
  assign wdata_src = writedata[NUM_IRQ-1:0];
  assign rise      = irq_in & ~irq_prev_q;
  assign masked    = pending_q & mask_q;
  assign w1c_pend  = (wr_en && address == A_PEND) ? wdata_src : '0;
  assign w1c_ovr   = (wr_en && address == A_OVRN) ? wdata_src : '0;
  // A mode change drops whatever was pending under the old mode.
  assign sel_chg   = (wr_en && address == A_EDGE) ? (wdata_src ^ edge_sel_q) : '0;
  assign tick_inc  = rise[TICK_SRC];
  // Bits above NUM_IRQ carry no state; fold them so they are visibly consumed.
  assign unused_wdata = ^writedata;

  // Next-state for pending/overrun/config/tick; a new edge beats a W1C clear.
  always_comb begin
    pending_d  = (edge_sel_q & (rise | (pending_q & ~w1c_pend))) | (~edge_sel_q & irq_in);
    pending_d  = pending_d & ~sel_chg;
    overrun_d  = (edge_sel_q & rise & pending_q) | (overrun_q & ~w1c_ovr);
    mask_d     = (wr_en && address == A_MASK) ? wdata_src : mask_q;
    edge_sel_d = (wr_en && address == A_EDGE) ? wdata_src : edge_sel_q;
    irq_d      = |masked;
    if (wr_en && address == A_TICK) begin
      tick_d = {15'd0, tick_inc};
    end else begin
      tick_d = tick_q + {15'd0, tick_inc};
    end
  end

  // Lowest-index pending and enabled source wins.
  always_comb begin
    active_idx = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (masked[i]) active_idx = 4'(i);
    end
  end

  // Read mux samples register state before any same-cycle write lands.
  always_comb begin
    readdata_d = 16'd0;
    case (address)
      A_PEND:  readdata_d = 16'(pending_q);
      A_MASK:  readdata_d = 16'(mask_q);
      A_EDGE:  readdata_d = 16'(edge_sel_q);
      A_ACTV:  readdata_d = {|masked, 11'd0, active_idx};
      A_OVRN:  readdata_d = 16'(overrun_q);
      A_TICK:  readdata_d = tick_q;
      default: readdata_d = 16'd0;
    endcase
  end

  // State registers; reset overrides any concurrent edge or write.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q  <= '0;
      mask_q     <= '0;
      edge_sel_q <= '0;
      overrun_q  <= '0;
      irq_prev_q <= '0;
      tick_q     <= 16'd0;
      readdata_q <= 16'd0;
      irq_q      <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      edge_sel_q <= edge_sel_d;
      overrun_q  <= overrun_d;
      irq_prev_q <= irq_in;
      tick_q     <= tick_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_sys_irq_ctrl.sv
// Testbench for sys_irq_ctrl: directed scenarios plus a randomized run
// compared cycle by cycle against a behavioural model of the register map.
module tb_sys_irq_ctrl;

  localparam int NUM_IRQ  = 8;
  localparam int TICK_SRC = 0;

  logic               clk = 1'b0;
  logic               reset;
  logic [2:0]         address;
  logic               chipselect;
  logic               write_n;
  logic [15:0]        writedata;
  logic [NUM_IRQ-1:0] irq_in;
  logic [15:0]        readdata;
  logic               irq;

  int checks = 0;
  int errors = 0;

  // Behavioural model state (16-bit views, unused bits stay 0)
  logic [15:0] m_pend, m_mask, m_sel, m_ovr, m_tick, m_prev, m_rd;
  logic        m_irq;

  sys_irq_ctrl #(.NUM_IRQ(NUM_IRQ), .TICK_SRC(TICK_SRC)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .irq_in     (irq_in),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // One bus cycle: drive, take the rising edge, advance the model, settle.
  task automatic cyc(input logic rst, input logic cs, input logic wn,
                     input logic [2:0] a, input logic [15:0] wd,
                     input logic [NUM_IRQ-1:0] in);
    logic        wr, r;
    logic [15:0] np, no, lowm, rd;
    reset = rst; chipselect = cs; write_n = wn; address = a;
    writedata = wd; irq_in = in;
    @(posedge clk);
    lowm = 16'((32'h1 << NUM_IRQ) - 1);
    wr   = cs && !wn;
    rd   = 16'h0000;
    case (a)
      3'd0: rd = m_pend;
      3'd1: rd = m_mask;
      3'd2: rd = m_sel;
      3'd3: begin
        for (int i = 0; i < NUM_IRQ; i++) begin
          if (m_pend[i] && m_mask[i]) begin
            rd = 16'h8000 | 16'(i);
            break;
          end
        end
      end
      3'd4: rd = m_ovr;
      3'd5: rd = m_tick;
      default: rd = 16'h0000;
    endcase
    if (rst) begin
      m_pend = 0; m_mask = 0; m_sel = 0; m_ovr = 0; m_tick = 0; m_prev = 0;
      m_rd = 0; m_irq = 0;
    end else begin
      m_rd  = rd;
      m_irq = (m_pend & m_mask) != 0;
      np = 0; no = 0;
      for (int i = 0; i < NUM_IRQ; i++) begin
        r = in[i] && !m_prev[i];
        if (m_sel[i]) begin
          if (r) np[i] = 1'b1;
          else if (wr && a == 3'd0 && wd[i]) np[i] = 1'b0;
          else np[i] = m_pend[i];
          if (r && m_pend[i]) no[i] = 1'b1;
          else if (wr && a == 3'd4 && wd[i]) no[i] = 1'b0;
          else no[i] = m_ovr[i];
        end else begin
          np[i] = in[i];
          if (wr && a == 3'd4 && wd[i]) no[i] = 1'b0;
          else no[i] = m_ovr[i];
        end
        if (wr && a == 3'd2 && (wd[i] != m_sel[i])) np[i] = 1'b0;
      end
      r = in[TICK_SRC] && !m_prev[TICK_SRC];
      if (wr && a == 3'd5) m_tick = r ? 16'd1 : 16'd0;
      else if (r) m_tick = m_tick + 16'd1;
      if (wr && a == 3'd1) m_mask = wd & lowm;
      if (wr && a == 3'd2) m_sel = wd & lowm;
      m_pend = np; m_ovr = no;
      m_prev = 16'(in);
    end
    #1;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [15:0] d);
    cyc(1'b0, 1'b1, 1'b0, a, d, irq_in);
  endtask

  task automatic rd_reg(input logic [2:0] a);
    cyc(1'b0, 1'b0, 1'b1, a, 16'h0000, irq_in);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b1, 3'd0, 16'h0000, '0);
    cyc(1'b1, 1'b0, 1'b1, 3'd0, 16'h0000, '0);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++)
      cyc(1'b1, 1'b1, 1'b0, 3'($urandom), 16'($urandom), NUM_IRQ'($urandom));
    checks++;
    if (readdata !== 16'h0000) begin
      errors++; $display("FAIL reset_readdata got %h expected 0000", readdata);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL reset_irq got %b expected 0", irq);
    end
    irq_in = '0;
    for (int a = 0; a < 8; a++) begin
      rd_reg(3'(a));
      checks++;
      if (readdata !== 16'h0000) begin
        errors++; $display("FAIL reset_reg%0d got %h expected 0000", a, readdata);
      end
    end
  endtask

  task automatic test_edge();
    do_reset();
    wr_reg(3'd1, 16'h0001);
    wr_reg(3'd2, 16'h0001);
    cyc(1'b0, 1'b0, 1'b1, 3'd0, 16'h0, 8'h01);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL edge_irq_t1 got %b expected 0", irq);
    end
    cyc(1'b0, 1'b0, 1'b1, 3'd0, 16'h0, 8'h00);
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL edge_irq_t2 got %b expected 1", irq);
    end
    rd_reg(3'd0);
    checks++;
    if (readdata !== 16'h0001) begin
      errors++; $display("FAIL edge_pending got %h expected 0001", readdata);
    end
    rd_reg(3'd3);
    checks++;
    if (readdata !== 16'h8000) begin
      errors++; $display("FAIL edge_active got %h expected 8000", readdata);
    end
    wr_reg(3'd0, 16'h0001);
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL edge_w1c_irq_t1 got %b expected 1", irq);
    end
    rd_reg(3'd0);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL edge_w1c_irq_t2 got %b expected 0", irq);
    end
  endtask

  task automatic test_overrun_tick();
    do_reset();
    wr_reg(3'd1, 16'h0001);
    wr_reg(3'd2, 16'h0001);
    cyc(1'b0, 1'b0, 1'b1, 3'd0, 16'h0, 8'h01);
    cyc(1'b0, 1'b0, 1'b1, 3'd0, 16'h0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 3'd0, 16'h0, 8'h01);
    cyc(1'b0, 1'b0, 1'b1, 3'd0, 16'h0, 8'h00);
    rd_reg(3'd4);
    checks++;
    if (readdata !== 16'h0001) begin
      errors++; $display("FAIL overrun got %h expected 0001", readdata);
    end
    rd_reg(3'd5);
    checks++;
    if (readdata !== 16'h0002) begin
      errors++; $display("FAIL tick_two got %h expected 0002", readdata);
    end
    // W1C on the same edge as a new rise: the rise must win
    cyc(1'b0, 1'b1, 1'b0, 3'd0, 16'h0001, 8'h01);
    cyc(1'b0, 1'b0, 1'b1, 3'd0, 16'h0, 8'h00);
    checks++;
    if (readdata !== 16'h0001) begin
      errors++; $display("FAIL set_beats_w1c got %h expected 0001", readdata);
    end
    wr_reg(3'd4, 16'h0001);
    rd_reg(3'd4);
    checks++;
    if (readdata !== 16'h0000) begin
      errors++; $display("FAIL overrun_w1c got %h expected 0000", readdata);
    end
  endtask

  task automatic test_level();
    logic exp;
    do_reset();
    wr_reg(3'd1, 16'h0008);
    for (int k = 0; k < 10; k++) begin
      if (k == 2) cyc(1'b0, 1'b1, 1'b0, 3'd0, 16'h0008, (k < 5) ? 8'h08 : 8'h00);
      else        cyc(1'b0, 1'b0, 1'b1, 3'd0, 16'h0000, (k < 5) ? 8'h08 : 8'h00);
      exp = (k >= 1 && k <= 5);
      checks++;
      if (irq !== exp) begin
        errors++; $display("FAIL level_irq k=%0d got %b expected %b", k, irq, exp);
      end
      if (k == 3) begin
        checks++;
        if (readdata !== 16'h0008) begin
          errors++; $display("FAIL level_w1c_ignored got %h expected 0008", readdata);
        end
      end
    end
  endtask

  task automatic test_active();
    do_reset();
    wr_reg(3'd2, 16'h0024);
    wr_reg(3'd1, 16'h0024);
    cyc(1'b0, 1'b0, 1'b1, 3'd0, 16'h0, 8'h24);
    cyc(1'b0, 1'b0, 1'b1, 3'd0, 16'h0, 8'h00);
    rd_reg(3'd3);
    checks++;
    if (readdata !== 16'h8002) begin
      errors++; $display("FAIL active_2 got %h expected 8002", readdata);
    end
    wr_reg(3'd1, 16'h0020);
    rd_reg(3'd3);
    checks++;
    if (readdata !== 16'h8005) begin
      errors++; $display("FAIL active_5 got %h expected 8005", readdata);
    end
    wr_reg(3'd1, 16'h0000);
    rd_reg(3'd3);
    checks++;
    if (readdata !== 16'h0000) begin
      errors++; $display("FAIL active_none got %h expected 0000", readdata);
    end
    // Flipping source 2 to level mode drops its pending bit
    wr_reg(3'd2, 16'h0020);
    rd_reg(3'd0);
    checks++;
    if (readdata !== 16'h0020) begin
      errors++; $display("FAIL sel_change got %h expected 0020", readdata);
    end
  endtask

  task automatic test_tick_wrap();
    do_reset();
    force dut.tick_q = 16'hFFFF;
    #1;
    release dut.tick_q;
    m_tick = 16'hFFFF;
    rd_reg(3'd5);
    checks++;
    if (readdata !== 16'hFFFF) begin
      errors++; $display("FAIL tick_preload got %h expected ffff", readdata);
    end
    cyc(1'b0, 1'b0, 1'b1, 3'd0, 16'h0, 8'h01);
    cyc(1'b0, 1'b0, 1'b1, 3'd5, 16'h0, 8'h00);
    rd_reg(3'd5);
    checks++;
    if (readdata !== 16'h0000) begin
      errors++; $display("FAIL tick_wrap got %h expected 0000", readdata);
    end
    cyc(1'b0, 1'b1, 1'b0, 3'd5, 16'h1234, 8'h01);
    cyc(1'b0, 1'b0, 1'b1, 3'd5, 16'h0, 8'h00);
    checks++;
    if (readdata !== 16'h0001) begin
      errors++; $display("FAIL tick_clear_on_edge got %h expected 0001", readdata);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    wr_reg(3'd1, 16'h00A5);
    wr_reg(3'd2, 16'h003C);
    rd_reg(3'd1);
    checks++;
    if (readdata !== 16'h00A5) begin
      errors++; $display("FAIL b2b_mask got %h expected 00a5", readdata);
    end
    rd_reg(3'd2);
    checks++;
    if (readdata !== 16'h003C) begin
      errors++; $display("FAIL b2b_sel got %h expected 003c", readdata);
    end
    wr_reg(3'd1, 16'hFF11);
    checks++;
    if (readdata !== 16'h00A5) begin
      errors++; $display("FAIL read_before_write got %h expected 00a5", readdata);
    end
    rd_reg(3'd1);
    checks++;
    if (readdata !== 16'h0011) begin
      errors++; $display("FAIL mask_upper_bits got %h expected 0011", readdata);
    end
    cyc(1'b0, 1'b1, 1'b0, 3'd6, 16'hFFFF, irq_in);
    checks++;
    if (readdata !== 16'h0000) begin
      errors++; $display("FAIL addr6 got %h expected 0000", readdata);
    end
    // chipselect low: write strobe must be ignored
    cyc(1'b0, 1'b0, 1'b0, 3'd1, 16'h00FF, irq_in);
    rd_reg(3'd1);
    checks++;
    if (readdata !== 16'h0011) begin
      errors++; $display("FAIL no_cs_write got %h expected 0011", readdata);
    end
  endtask

  task automatic test_reset_midop();
    wr_reg(3'd2, 16'h00FF);
    wr_reg(3'd1, 16'h00FF);
    cyc(1'b0, 1'b0, 1'b1, 3'd0, 16'h0, 8'hFF);
    cyc(1'b1, 1'b1, 1'b0, 3'd1, 16'h00FF, 8'h00);
    cyc(1'b1, 1'b1, 1'b0, 3'd2, 16'h00FF, 8'hFF);
    checks++;
    if (irq !== 1'b0 || readdata !== 16'h0000) begin
      errors++; $display("FAIL midop_reset got irq=%b rd=%h expected 0/0000", irq, readdata);
    end
    irq_in = '0;
    for (int a = 0; a < 6; a++) begin
      rd_reg(3'(a));
      checks++;
      if (readdata !== 16'h0000) begin
        errors++; $display("FAIL midop_reg%0d got %h expected 0000", a, readdata);
      end
    end
  endtask

  task automatic test_random();
    logic [NUM_IRQ-1:0] in;
    logic               rst, cs, wn;
    do_reset();
    in = '0;
    for (int n = 0; n < 1500; n++) begin
      in  = in ^ NUM_IRQ'($urandom & $urandom);
      rst = ($urandom_range(0, 199) == 0);
      cs  = ($urandom_range(0, 3) != 0);
      wn  = ($urandom_range(0, 2) != 0);
      cyc(rst, cs, wn, 3'($urandom), 16'($urandom), in);
      checks++;
      if (readdata !== m_rd) begin
        errors++; $display("FAIL rand_readdata n=%0d addr=%0d got %h expected %h", n, address, readdata, m_rd);
      end
      checks++;
      if (irq !== m_irq) begin
        errors++; $display("FAIL rand_irq n=%0d got %b expected %b", n, irq, m_irq);
      end
    end
  endtask

  initial begin
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 3'd0;
    writedata = 16'h0; irq_in = '0;
    m_pend = 0; m_mask = 0; m_sel = 0; m_ovr = 0; m_tick = 0; m_prev = 0;
    m_rd = 0; m_irq = 0;
    test_reset();
    test_edge();
    test_overrun_tick();
    test_level();
    test_active();
    test_tick_wrap();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
